// File: rtl/rabbit_serial_frame_rx.sv
// rabbit_serial_frame_rx: oversampled MSB-first serial frame receiver with channel header,
// length check, inactivity timeout and one-cycle valid/error strobes.
module rabbit_serial_frame_rx #(
    parameter int FRAME_BITS     = 184,
    parameter int CH_BITS        = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic                  init_key_flag,
    input  logic                  SCLK_PE_3,
    input  logic                  SDIO_PE_5,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic [CH_BITS-1:0]    frame_ch,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int TOTAL = CH_BITS + FRAME_BITS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES:0]    sdio_sync_q, sdio_sync_d;
    logic [SYNC_STAGES-1:0]  en_sync_q, en_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    en_prev_q, en_prev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [TOTAL-1:0]        shift_q, shift_d;
    logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
    logic [CH_BITS-1:0]      frame_ch_q, frame_ch_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    sclk_rise, en_lvl, en_fall, sdio_bit, last_edge;

    // SDIO is one stage deeper than the SCLK sync chain so it lines up with the edge compare
    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign en_lvl    = en_sync_q[SYNC_STAGES-1];
    assign en_fall   = en_prev_q & ~en_lvl;
    assign sdio_bit  = sdio_sync_q[SYNC_STAGES];
    assign last_edge = sclk_rise && (cnt_q == CW'(TOTAL - 1));

    assign frame_data  = frame_data_q;
    assign frame_ch    = frame_ch_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q == SHIFT);

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], SCLK_PE_3};
        sdio_sync_d  = {sdio_sync_q[SYNC_STAGES-1:0], SDIO_PE_5};
        en_sync_d    = {en_sync_q[SYNC_STAGES-2:0], init_key_flag};
        sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
        en_prev_d    = en_sync_q[SYNC_STAGES-1];
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        shift_d      = shift_q;
        frame_data_d = frame_data_q;
        frame_ch_d   = frame_ch_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            SHIFT: begin
                // A final edge coinciding with enable release still completes the frame
                if (cnt_q == CW'(TOTAL)) begin
                    frame_data_d = shift_q[FRAME_BITS-1:0];
                    frame_ch_d   = shift_q[TOTAL-1 -: CH_BITS];
                    valid_d      = 1'b1;
                    state_d      = en_lvl ? IDLE : HOLD;
                end else if (en_lvl && !last_edge) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[TOTAL-2:0], sdio_bit};
                    cnt_d   = cnt_q + CW'(1);
                    tmo_d   = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            HOLD: begin
                if (en_lvl) state_d = IDLE;
                else if (sclk_rise) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            sdio_sync_q  <= '0;
            en_sync_q    <= '1;
            sclk_prev_q  <= 1'b0;
            en_prev_q    <= 1'b1;
            cnt_q        <= '0;
            tmo_q        <= '0;
            shift_q      <= '0;
            frame_data_q <= '0;
            frame_ch_q   <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            sdio_sync_q  <= sdio_sync_d;
            en_sync_q    <= en_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            en_prev_q    <= en_prev_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            shift_q      <= shift_d;
            frame_data_q <= frame_data_d;
            frame_ch_q   <= frame_ch_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end
endmodule

// File: tb/tb_rabbit_serial_frame_rx.sv
// tb_rabbit_serial_frame_rx: scoreboard bench driving a default-size and a small receiver
// through complete, short, timed-out, over-long and reset-interrupted frames.
module tb_rabbit_serial_frame_rx;
    logic clk = 1'b0;
    logic rst, sclk, sdio, en, sel;
    logic en0, en1;
    logic [183:0] d0;
    logic [7:0]   d1;
    logic [1:0]   ch0, ch1;
    logic v0, e0, b0, v1, e1, b1;
    int cyc = 0;
    int tests = 0, fails = 0;
    int rise_cyc = 0, vcyc1 = 0, ecyc1 = 0;

    typedef struct packed {
        logic         err;
        logic [1:0]   ch;
        logic [183:0] data;
    } exp_t;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // only the selected receiver sees the enable window; the other stays idle
    assign en0 = sel ? 1'b1 : en;
    assign en1 = sel ? en : 1'b1;

    rabbit_serial_frame_rx dut0 (
        .CLK_50(clk), .RESET(rst), .init_key_flag(en0), .SCLK_PE_3(sclk), .SDIO_PE_5(sdio),
        .frame_data(d0), .frame_ch(ch0), .frame_valid(v0), .frame_err(e0), .busy(b0)
    );

    rabbit_serial_frame_rx #(.FRAME_BITS(8), .CH_BITS(2), .TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut1 (
        .CLK_50(clk), .RESET(rst), .init_key_flag(en1), .SCLK_PE_3(sclk), .SDIO_PE_5(sdio),
        .frame_data(d1), .frame_ch(ch1), .frame_valid(v1), .frame_err(e1), .busy(b1)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic err, input logic [1:0] ch, input logic [183:0] data);
        exp_t x;
        x.err = err; x.ch = ch; x.data = data;
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic check_ev(input int d, input logic v, input logic e, input logic [1:0] ch,
                            input logic [183:0] data);
        exp_t x;
        tests++;
        if (v && e) begin
            fails++;
            $display("FAIL dut%0d_both_strobes: valid=%b err=%b expected never both", d, v, e);
        end else if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL dut%0d_unexpected: valid=%b err=%b ch=%0d data=%0h expected no strobe", d, v, e, ch, data);
        end else begin
            x = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (x.err !== e || x.ch !== ch || x.data !== data) begin
                fails++;
                $display("FAIL dut%0d_event: got err=%b ch=%0d data=%0h expected err=%b ch=%0d data=%0h",
                         d, e, ch, data, x.err, x.ch, x.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (v0 || e0) check_ev(0, v0, e0, ch0, d0);
        if (v1 || e1) begin
            if (v1) vcyc1 = cyc;
            if (e1) ecyc1 = cyc;
            check_ev(1, v1, e1, ch1, {176'b0, d1});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdio = b;
        sclk = 1'b0;
        tick(5);
        sclk = 1'b1;
        rise_cyc = cyc;
        tick(5);
    endtask

    task automatic send_bits(input logic [185:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(v[i]);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [185:0] fa, fc, fs;
        int diff;
        fa = {2'b10, {23{8'hA5}}};
        fc = {2'b11, {23{8'h3C}}};
        rst = 1'b1; en = 1'b1; sclk = 1'b0; sdio = 1'b0; sel = 1'b0;
        tick(3);
        chk("rst_d0", d0, 0);
        chk("rst_ch0", ch0, 0);
        chk("rst_strobes0", {v0, e0, b0}, 0);
        chk("rst_d1", d1, 0);
        chk("rst_strobes1", {v1, e1, b1}, 0);
        rst = 1'b0;
        tick(5);

        // default-size frame on channel 2
        push(0, 1'b0, 2'd2, {23{8'hA5}});
        en = 1'b0; tick(5);
        send_bits(fa, 185, 166);
        chk("busy_mid_frame", b0, 1);
        send_bits(fa, 165, 0);
        en = 1'b1; tick(10);
        chk("busy_after_frame", b0, 0);

        // small frame 01_11001010 and its latency
        sel = 1'b1;
        fs = 186'b01_11001010;
        push(1, 1'b0, 2'd1, 184'hCA);
        en = 1'b0; tick(5);
        send_bits(fs, 9, 0);
        chk("valid_latency", vcyc1 - rise_cyc, 4);
        en = 1'b1; tick(10);

        // short frame aborted by enable release
        push(1, 1'b1, 2'd1, 184'hCA);
        en = 1'b0; tick(5);
        send_bits(fs, 9, 4);
        en = 1'b1; tick(10);
        chk("short_keeps_data", d1, 8'hCA);
        chk("short_idle", b1, 0);

        // inactivity timeout, then extra edges in HOLD
        push(1, 1'b1, 2'd1, 184'hCA);
        en = 1'b0; tick(5);
        send_bits(fs, 9, 5);
        tick(80);
        diff = ecyc1 - rise_cyc;
        chk("timeout_window", (diff >= 64 && diff <= 70), 1);
        chk("timeout_busy", b1, 0);
        repeat (3) push(1, 1'b1, 2'd1, 184'hCA);
        send_bits(fs, 2, 0);
        en = 1'b1; tick(10);

        // complete frame followed by two surplus edges
        fs = 186'b11_00111100;
        push(1, 1'b0, 2'd3, 184'h3C);
        push(1, 1'b1, 2'd3, 184'h3C);
        push(1, 1'b1, 2'd3, 184'h3C);
        en = 1'b0; tick(5);
        send_bits(fs, 9, 0);
        send_bits(fs, 1, 0);
        en = 1'b1; tick(10);
        chk("surplus_keeps_data", d1, 8'h3C);

        // final edge and enable release together: frame still completes
        fs = 186'b00_01011010;
        push(1, 1'b0, 2'd0, 184'h5A);
        en = 1'b0; tick(5);
        send_bits(fs, 9, 1);
        sdio = fs[0]; sclk = 1'b0; tick(5);
        sclk = 1'b1; en = 1'b1; rise_cyc = cyc;
        tick(10);
        chk("simul_latency", vcyc1 - rise_cyc, 4);
        chk("simul_idle", b1, 0);

        // reset mid-frame, then a clean frame on channel 3
        sel = 1'b0;
        en = 1'b0; tick(5);
        send_bits(fa, 185, 136);
        rst = 1'b1; en = 1'b1; tick(2);
        chk("midrst_d0", d0, 0);
        chk("midrst_strobes0", {v0, e0, b0}, 0);
        chk("midrst_d1", d1, 0);
        rst = 1'b0; tick(5);
        push(0, 1'b0, 2'd3, {23{8'h3C}});
        en = 1'b0; tick(5);
        send_bits(fc, 185, 0);
        en = 1'b1; tick(10);
        chk("final_d0", d0, {23{8'h3C}});

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
